// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: redirect input, imem request/response and the decode handshake.
// master = fetch unit, slave = surrounding core (redirect source, imem, decode).
interface fetch_unit_if;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic [63:0] imem_pc_addr;
    logic [31:0] imem_instruction;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic        id_exc_en;
    logic [3:0]  id_exc_code;
    logic [63:0] id_exc_val;

    modport master (
        input  redirect_en, redirect_pc,
        output imem_pc_addr,
        input  imem_instruction, imem_exc_en, imem_exc_code, imem_exc_val,
        output id_valid,
        input  id_ready,
        output id_pc, id_instr, id_exc_en, id_exc_code, id_exc_val
    );

    modport slave (
        output redirect_en, redirect_pc,
        input  imem_pc_addr,
        output imem_instruction, imem_exc_en, imem_exc_code, imem_exc_val,
        input  id_valid,
        output id_ready,
        input  id_pc, id_instr, id_exc_en, id_exc_code, id_exc_val
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, buffers fetched words in a 2-entry FIFO toward decode,
// and halts after enqueuing exactly one faulting entry until a redirect or reset.
module fetch_unit #(
    parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_0000,
    parameter logic [31:0] NOP_INSN     = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } entry_t;

    typedef enum logic {RUN, HALT} state_t;

    state_t      r_state, w_state_nxt;
    logic [63:0] r_pc, w_pc_nxt;
    logic [1:0]  r_count;
    logic        r_wptr, r_rptr;
    entry_t      r_mem [2];

    logic        w_valid, w_pop, w_room, w_push;
    entry_t      w_entry, w_head;

    assign w_valid = (r_count != 2'd0);
    assign w_pop   = w_valid && bus.id_ready;
    assign w_room  = (r_count < 2'd2) || w_pop;
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    // Fault entries freeze the PC on the faulting address so the exception value stays observable.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_entry     = '0;
        if (bus.redirect_en) begin
            w_state_nxt = RUN;
            w_pc_nxt    = bus.redirect_pc;
        end else if (r_state == RUN && w_room) begin
            w_push = 1'b1;
            if (r_pc[1:0] != 2'b00) begin
                w_entry     = '{pc: r_pc, instr: NOP_INSN, exc_en: 1'b1, exc_code: 4'd0, exc_val: r_pc};
                w_state_nxt = HALT;
            end else if (bus.imem_exc_en) begin
                w_entry     = '{pc: r_pc, instr: NOP_INSN, exc_en: 1'b1,
                                exc_code: bus.imem_exc_code, exc_val: bus.imem_exc_val};
                w_state_nxt = HALT;
            end else begin
                w_entry  = '{pc: r_pc, instr: bus.imem_instruction, exc_en: 1'b0,
                             exc_code: 4'd0, exc_val: 64'd0};
                w_pc_nxt = r_pc + 64'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_pc <= RESET_VECTOR;
        else     r_pc <= w_pc_nxt;
    end

    // A redirect voids any pop in the same cycle, so the flush simply clears everything.
    always_ff @(posedge clk) begin
        if (rst || bus.redirect_en) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_entry;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign bus.imem_pc_addr = r_pc;
    assign bus.id_valid     = w_valid;
    assign bus.id_pc        = w_valid ? w_head.pc       : 64'd0;
    assign bus.id_instr     = w_valid ? w_head.instr    : NOP_INSN;
    assign bus.id_exc_en    = w_valid ? w_head.exc_en   : 1'b0;
    assign bus.id_exc_code  = w_valid ? w_head.exc_code : 4'd0;
    assign bus.id_exc_val   = w_valid ? w_head.exc_val  : 64'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Random-stimulus bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
    localparam logic [63:0] RV  = 64'h0;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_VECTOR(RV), .NOP_INSN(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // imem behaviour: deterministic functions of the address so the model can recompute them.
    function automatic logic [31:0] f_instr(input logic [63:0] a);
        return a[31:0] ^ 32'hC3A5_0000 ^ {a[15:0], a[31:16]};
    endfunction
    function automatic logic f_fault(input logic [63:0] a);
        return (a[7:2] == 6'h2A) || (a == 64'h2000);
    endfunction
    function automatic logic [3:0] f_code(input logic [63:0] a);
        return (a == 64'h2000) ? 4'd1 : (a[11:8] | 4'd1);
    endfunction
    function automatic logic [63:0] f_val(input logic [63:0] a);
        return (a == 64'h2000) ? a : (a ^ 64'h0000_0000_00F0_0000);
    endfunction

    assign bus.imem_instruction = f_instr(bus.imem_pc_addr);
    assign bus.imem_exc_en      = f_fault(bus.imem_pc_addr);
    assign bus.imem_exc_code    = f_code(bus.imem_pc_addr);
    assign bus.imem_exc_val     = f_val(bus.imem_pc_addr);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } ent_t;

    ent_t        m_q[$];
    logic [63:0] m_pc;
    bit          m_halted;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of architectural behaviour: reset, else redirect, else pop then maybe fetch.
    task automatic model_step(input bit r, input bit redir, input logic [63:0] rpc, input bit rdy);
        bit pop, room;
        ent_t e;
        if (r) begin
            m_q.delete(); m_pc = RV; m_halted = 0;
            return;
        end
        pop = (m_q.size() > 0) && rdy;
        if (redir) begin
            m_q.delete(); m_pc = rpc; m_halted = 0;
            return;
        end
        room = (m_q.size() < 2) || pop;
        if (pop) void'(m_q.pop_front());
        if (!m_halted && room) begin
            if (m_pc % 4 != 0) begin
                e = '{m_pc, NOP, 1'b1, 4'd0, m_pc};
                m_halted = 1;
            end else if (f_fault(m_pc)) begin
                e = '{m_pc, NOP, 1'b1, f_code(m_pc), f_val(m_pc)};
                m_halted = 1;
            end else begin
                e = '{m_pc, f_instr(m_pc), 1'b0, 4'd0, 64'd0};
                m_pc = m_pc + 4;
            end
            m_q.push_back(e);
        end
    endtask

    task automatic compare_outputs();
        chk("imem_pc_addr", bus.imem_pc_addr, m_pc);
        chk("id_valid", {63'd0, bus.id_valid}, {63'd0, m_q.size() > 0});
        if (m_q.size() > 0) begin
            chk("id_pc",       bus.id_pc,                m_q[0].pc);
            chk("id_instr",    {32'd0, bus.id_instr},    {32'd0, m_q[0].instr});
            chk("id_exc_en",   {63'd0, bus.id_exc_en},   {63'd0, m_q[0].exc_en});
            chk("id_exc_code", {60'd0, bus.id_exc_code}, {60'd0, m_q[0].exc_code});
            chk("id_exc_val",  bus.id_exc_val,           m_q[0].exc_val);
        end else begin
            chk("empty_pc",    bus.id_pc,                64'd0);
            chk("empty_instr", {32'd0, bus.id_instr},    {32'd0, NOP});
            chk("empty_exc",   {59'd0, bus.id_exc_en, bus.id_exc_code}, 64'd0);
            chk("empty_val",   bus.id_exc_val,           64'd0);
        end
    endtask

    // Drive one cycle's inputs at the negedge and advance the model to match the next posedge.
    task automatic cycle(input bit r, input bit redir, input logic [63:0] rpc, input bit rdy);
        @(negedge clk);
        compare_outputs();
        rst             = r;
        bus.redirect_en = redir;
        bus.redirect_pc = rpc;
        bus.id_ready    = rdy;
        model_step(r, redir, rpc, rdy);
    endtask

    initial begin
        logic [63:0] tgt;
        bit r, rd, rdy;
        rst = 1'b1; bus.redirect_en = 1'b0; bus.redirect_pc = 64'd0; bus.id_ready = 1'b1;
        model_step(1, 0, 0, 1);
        repeat (2) @(posedge clk);

        // Directed prologue: stall, fill, redirect, imem fault, misaligned, wrap, reset while halted.
        cycle(1, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 1);
        cycle(0, 1, 64'h100, 1);
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 64'h2000, 1);
        repeat (12) cycle(0, 0, 0, 1);
        cycle(0, 1, 64'h40, 1);
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 64'h102, 0);
        repeat (4) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 1);
        repeat (4) cycle(0, 0, 0, 1);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            rd  = ($urandom_range(0, m_halted ? 3 : 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 | {60'd0, 2'($urandom_range(0, 3)), 2'b00};
                1:       tgt = {52'd0, 12'($urandom)};
                2:       tgt = 64'h2000;
                default: tgt = {54'd0, 8'($urandom), 2'b00};
            endcase
            cycle(r, rd, tgt, rdy);
        end
        @(negedge clk);
        compare_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
